// File: rtl/alu_req_seq.sv
// Sequential A/B/opcode initiator for the 4-bit nvboard ALU: one enter press per field,
// then one execute cycle that captures the result and flags. Optional debouncer: ALU_SEQ_DEBOUNCE_EN.
module alu_req_seq #(
  parameter int CNT_W      = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       sw,
  input  logic             btn_enter,
  input  logic             btn_clr,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [3:0]       alu_out,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic             alu_c,
  output logic [3:0]       res,
  output logic [2:0]       flags,
  output logic             done,
  output logic [2:0]       stage,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  // Bit 0 carries the enter button, bit 1 the clear button.
  logic [1:0] s1, s2, s3, lvl;
  logic       enter_p, clr_p;

  // NOTE: every flop is updated with <= so all registers sample the pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {btn_clr, btn_enter};
      s2 <= s1;
      s3 <= lvl;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic [1:0]    deb;
  logic [DW-1:0] deb_cnt [2];

  // The level only follows s2 once it has differed for DEB_CYCLES consecutive samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i]     <= s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = deb;
`else
  assign lvl = s2;
`endif

  assign enter_p = lvl[0] & ~s3[0];
  assign clr_p   = lvl[1] & ~s3[1];

  state_t           state, state_n;
  logic [3:0]       a_n, b_n, res_n;
  logic [2:0]       sel_n, flags_n;
  logic             done_n;
  logic [CNT_W-1:0] cnt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_A;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      res     <= '0;
      flags   <= '0;
      done    <= 1'b0;
      op_cnt  <= '0;
    end else begin
      state   <= state_n;
      alu_a   <= a_n;
      alu_b   <= b_n;
      alu_sel <= sel_n;
      res     <= res_n;
      flags   <= flags_n;
      done    <= done_n;
      op_cnt  <= cnt_n;
    end
  end

  // NOTE: every output of this block gets a hold value first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    a_n     = alu_a;
    b_n     = alu_b;
    sel_n   = alu_sel;
    res_n   = res;
    flags_n = flags;
    done_n  = done;
    cnt_n   = op_cnt;
    if (clr_p) begin
      // Clear beats a simultaneous enter; the operation count survives.
      state_n = S_A;
      a_n     = '0;
      b_n     = '0;
      sel_n   = '0;
      res_n   = '0;
      flags_n = '0;
      done_n  = 1'b0;
    end else begin
      unique case (state)
        S_A: if (enter_p) begin
          a_n     = sw;
          state_n = S_B;
        end
        S_B: if (enter_p) begin
          b_n     = sw;
          state_n = S_OP;
        end
        S_OP: if (enter_p) begin
          sel_n   = sw[2:0];
          state_n = S_EXEC;
        end
        S_EXEC: begin
          res_n   = alu_out;
          flags_n = {alu_zero, alu_ovf, alu_c};
          done_n  = 1'b1;
          cnt_n   = op_cnt + 1'b1;
          state_n = S_SHOW;
        end
        S_SHOW: if (enter_p) begin
          done_n  = 1'b0;
          state_n = S_A;
        end
        default: state_n = S_A;
      endcase
    end
  end

  assign stage = state;

endmodule

// File: tb/tb_alu_req_seq.sv
// Self-checking bench for alu_req_seq with a reference ALU attached and a result scoreboard.
module tb_alu_req_seq;

  localparam int CNT_W = 2;
  localparam int DEB   = 16;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int HOLD = DEB + 4;
  localparam int LAT  = DEB + 4;
`else
  localparam int HOLD = 3;
  localparam int LAT  = 4;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sw = '0;
  logic btn_enter = 1'b0, btn_clr = 1'b0;
  logic [3:0] alu_a, alu_b, alu_out, res;
  logic [2:0] alu_sel, flags, stage;
  logic alu_zero, alu_ovf, alu_c, done;
  logic [CNT_W-1:0] op_cnt;

  always #5 clk = ~clk;

  alu_req_seq #(.CNT_W(CNT_W), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_enter(btn_enter), .btn_clr(btn_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_c(alu_c), .res(res), .flags(flags),
    .done(done), .stage(stage), .op_cnt(op_cnt)
  );

  // Reference ALU, returns {out, zero, ovf, c}.
  function automatic logic [6:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    logic [4:0] w;
    logic [3:0] o;
    logic v, c;
    v = 1'b0;
    c = 1'b0;
    case (sel)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; o = w[3:0]; c = w[4]; v = (a[3] == b[3]) && (o[3] != a[3]); end
      3'd1: begin w = {1'b0, a} - {1'b0, b}; o = w[3:0]; c = w[4]; v = (a[3] != b[3]) && (o[3] != a[3]); end
      3'd2: o = ~a;
      3'd3: o = a & b;
      3'd4: o = a | b;
      3'd5: o = a ^ b;
      3'd6: o = {3'b000, $signed(a) < $signed(b)};
      default: o = {3'b000, a == b};
    endcase
    return {o, o == 4'd0, v, c};
  endfunction

  always_comb begin
    {alu_out, alu_zero, alu_ovf, alu_c} = alu_ref(alu_a, alu_b, alu_sel);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]       res;
    logic [2:0]       flags;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic done_q = 1'b0;

  // Compare each newly valid result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done && !done_q) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_res", res, e.res);
        check("sb_flags", flags, e.flags);
        check("sb_op_cnt", op_cnt, e.cnt);
      end
    end
    done_q <= done;
  end

  task automatic press(input logic [3:0] v);
    @(negedge clk);
    sw = v;
    btn_enter = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_enter = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic press_clr();
    @(negedge clk);
    btn_clr = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_clr = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    exp_t e;
    logic [6:0] r;
    int lat;
    press(a);
    check("stage_after_a", stage, 3'd1);
    press(b);
    check("stage_after_b", stage, 3'd2);
    r = alu_ref(a, b, sel);
    exp_cnt = exp_cnt + 1'b1;
    e.res = r[6:3];
    e.flags = r[2:0];
    e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    sw = {1'b1, sel};
    btn_enter = 1'b1;
    lat = 0;
    while (!done && lat < LAT + 10) begin
      @(negedge clk);
      lat++;
      if (lat == LAT - 1) check("stage_exec", stage, 3'd3);
    end
    check("done_latency", lat, LAT);
    check("stage_show", stage, 3'd4);
    check("alu_a_held", alu_a, a);
    check("alu_b_held", alu_b, b);
    check("alu_sel_latched", alu_sel, sel);
    repeat (HOLD) @(negedge clk);
    btn_enter = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_stage", stage, 3'd0);
    check("rst_alu_a", alu_a, 4'd0);
    check("rst_alu_b", alu_b, 4'd0);
    check("rst_alu_sel", alu_sel, 3'd0);
    check("rst_res", res, 4'd0);
    check("rst_flags", flags, 3'd0);
    check("rst_done", done, 1'b0);
    check("rst_op_cnt", op_cnt, 2'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Add with signed overflow: 7 + 1 = 8.
    run_op(4'b0111, 4'b0001, 3'd0);
    check("add_res", res, 4'b1000);
    check("add_flags", flags, 3'b010);
    check("add_op_cnt", op_cnt, 2'd1);
    press(4'h0);
    check("show_exit_stage", stage, 3'd0);
    check("show_exit_done", done, 1'b0);
    check("show_exit_res", res, 4'b1000);

    // Subtract to zero.
    run_op(4'b0011, 4'b0011, 3'd1);
    check("sub_res", res, 4'b0000);
    check("sub_flags", flags, 3'b100);
    press(4'h0);
    check("sub_exit_stage", stage, 3'd0);
    check("sub_exit_res", res, 4'b0000);

    // Clear after A and B are latched.
    press(4'b1010);
    press(4'b0101);
    check("pre_clr_b", alu_b, 4'b0101);
    press_clr();
    check("clr_stage", stage, 3'd0);
    check("clr_alu_a", alu_a, 4'd0);
    check("clr_alu_b", alu_b, 4'd0);
    check("clr_done", done, 1'b0);
    check("clr_op_cnt", op_cnt, exp_cnt);

    // Clear and enter raised together: clear wins.
    press(4'b0110);
    @(negedge clk);
    sw = 4'b1111;
    btn_enter = 1'b1;
    btn_clr = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_enter = 1'b0;
    btn_clr = 1'b0;
    repeat (HOLD) @(negedge clk);
    check("both_stage", stage, 3'd0);
    check("both_alu_a", alu_a, 4'd0);
    check("both_alu_b", alu_b, 4'd0);

    // Held enter gives a single advance.
    @(negedge clk);
    sw = 4'h3;
    btn_enter = 1'b1;
    repeat (50) @(negedge clk);
    check("held_stage", stage, 3'd1);
    btn_enter = 1'b0;
    repeat (HOLD) @(negedge clk);
    check("held_release_stage", stage, 3'd1);
    press(4'h4);
    check("held_repress_stage", stage, 3'd2);
    press_clr();
    check("held_clr_stage", stage, 3'd0);

    // Three more operations take the counter through 3, 0 (wrap), 1.
    run_op(4'b1001, 4'b0111, 3'd0);
    press(4'h0);
    run_op(4'b1100, 4'b0101, 3'd6);
    check("wrap_op_cnt", op_cnt, 2'd0);
    press(4'h0);
    run_op(4'b0110, 4'b0110, 3'd7);
    check("wrap_next_op_cnt", op_cnt, 2'd1);
    press_clr();
    check("show_clr_stage", stage, 3'd0);
    check("show_clr_res", res, 4'd0);
    check("show_clr_flags", flags, 3'd0);
    check("show_clr_done", done, 1'b0);
    check("show_clr_op_cnt", op_cnt, 2'd1);

`ifdef ALU_SEQ_DEBOUNCE_EN
    begin
      int n;
      @(negedge clk);
      sw = 4'h2;
      btn_enter = 1'b1;
      repeat (10) @(negedge clk);
      btn_enter = 1'b0;
      repeat (40) @(negedge clk);
      check("glitch_stage", stage, 3'd0);
      @(negedge clk);
      btn_enter = 1'b1;
      n = 0;
      while (stage == 3'd0 && n < 60) begin
        @(negedge clk);
        n++;
      end
      check("deb_advance_cycles", n, DEB + 3);
      repeat (20 - n) @(negedge clk);
      btn_enter = 1'b0;
      repeat (40) @(negedge clk);
      check("deb_stage", stage, 3'd1);
      press_clr();
    end
`endif

    // Reset in the middle of entry.
    press(4'b0101);
    check("pre_rst_stage", stage, 3'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_stage", stage, 3'd0);
    check("midrst_alu_a", alu_a, 4'd0);
    check("midrst_op_cnt", op_cnt, 2'd0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_req_seq.md
Name: alu_req_seq

Overview:
- Sequential operand/opcode initiator for the 4-bit combinational ALU on the nvboard bench.
- Collects A, B and opcode from a 4-bit switch bank, one "enter" button press per field, then drives them to the ALU.
- Captures the ALU result and the zero/overflow/carry flags into display registers and counts completed operations.
- Sits between the board switches/buttons and the ALU instance; its outputs feed the LEDs and 7-segment decode.

Parameters:
- CNT_W, 4, width of the completed-operation counter.
- DEB_CYCLES, 16, stable-sample count for the button debouncer; only used when ALU_SEQ_DEBOUNCE_EN is defined.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw  in  4  switch bank: operand value, or opcode in sw[2:0]
- btn_enter  in  1  raw, asynchronous enter button, active-high
- btn_clr  in  1  raw, asynchronous clear button, active-high
- alu_a  out  4  operand A to ALU
- alu_b  out  4  operand B to ALU
- alu_sel  out  3  opcode to ALU
- alu_out  in  4  ALU result
- alu_zero  in  1  ALU zero flag
- alu_ovf  in  1  ALU signed-overflow flag
- alu_c  in  1  ALU carry/borrow flag
- res  out  4  captured result
- flags  out  3  captured {zero, ovf, c}
- done  out  1  high while the captured result is valid
- stage  out  3  state code, drives LEDs
- op_cnt  out  CNT_W  number of completed operations

Behaviour:
- Reset (async assert, sync release): state S_A; alu_a, alu_b, alu_sel, res, flags, op_cnt = 0; done = 0; stage = 3'd0.
- Button input conditioning (each button): 2-FF synchronizer plus a third edge-detect flop.
  - enter_p / clr_p = s2 & ~s3: exactly one cycle high per press.
  - Asserted 2 clk edges after the first edge that samples the raw rising level.
  - A held button produces a single pulse.
- State codes on stage: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
- S_A: on enter_p, alu_a <= sw; go to S_B.
- S_B: on enter_p, alu_b <= sw; go to S_OP.
- S_OP: on enter_p, alu_sel <= sw[2:0], sw[3] ignored; go to S_EXEC.
- S_EXEC: exactly one cycle, no button needed.
  - ALU inputs are stable from register outputs for that cycle.
  - At its closing edge: res <= alu_out; flags <= {alu_zero, alu_ovf, alu_c}; done <= 1; op_cnt <= op_cnt+1; go to S_SHOW.
- Latency: done rises 2 cycles after the enter_p that latched the opcode.
- S_SHOW: on enter_p, done <= 0; go to S_A.
  - alu_a, alu_b, alu_sel, res and flags hold their values until overwritten.
- op_cnt wraps from 2^CNT_W-1 to 0 silently.
- clr_p in any state, including S_EXEC:
  - Next state S_A; alu_a, alu_b, alu_sel, res, flags = 0; done = 0.
  - op_cnt is not cleared; only rst_n clears it.
- clr_p and enter_p in the same cycle: clr_p wins and enter_p is discarded.
- In any state, enter_p is ignored unless it is listed for that state.
- Outputs alu_a, alu_b, alu_sel, res, flags, done, stage and op_cnt are all registered; no combinational path from inputs to outputs.
- rst_n asserted mid-operation: immediate return to reset values; any partially entered operands are lost.

Optional Feature:
- Macro: ALU_SEQ_DEBOUNCE_EN.
- Defined:
  - Each synchronized button passes through a debouncer before the edge-detect flop.
  - The debounced level changes only after s2 holds the new value for DEB_CYCLES consecutive cycles; the counter restarts on any toggle.
  - The pulse appears DEB_CYCLES+2 cycles after the raw edge; a bounce shorter than DEB_CYCLES yields no pulse.
- Undefined: no debouncer and no counter logic; timing exactly as in Behaviour. DEB_CYCLES is unused.

Test Plan:
- Add with signed overflow: sw=0111 enter, sw=0001 enter, sw=x000 enter (ALU model connected).
  - stage 0→1→2→3→4.
  - done rises 2 cycles after the third enter_p.
  - res=1000, flags={0,1,0}, op_cnt=1.
- Sub to zero: A=0011, B=0011, sel=001.
  - res=0000, flags={1,0,0}.
  - Enter in S_SHOW → stage=0, done=0, res still 0000.
- Clear mid-entry: latch A=1010 and B=0101, then press clr.
  - stage=0; alu_a, alu_b = 0; done=0; op_cnt unchanged.
  - clr and enter raw-asserted in the same cycle → only clr takes effect.
- Held button: hold btn_enter for 50 cycles in S_A → exactly one transition to S_B; no further advance until release and re-press.
- Counter wrap: CNT_W=2, run 5 complete operations → op_cnt sequence 1,2,3,0,1.
- Debounce (ALU_SEQ_DEBOUNCE_EN, DEB_CYCLES=16):
  - A 10-cycle glitch on btn_enter → no state change.
  - A 20-cycle press → one advance, with the pulse 18 cycles after the raw edge.
